// File: rtl/issue_stage.sv
// Purpose: in-order issue with 32x32 register file, writeback bypass and per-register pending scoreboard.
// Latency: a hazard-free stage-3 instruction appears on the stage-4 outputs after one clk edge.
// Backpressure: ready3 drops on RAW/WAW hazards; flush overrides and drops the instruction; stage 4 never stalls.
// Ports: clk/nrst; stage-3 instruction (valid3/ready3, rs1_3, rs2_3, rd3, use_*, we3, imm3, pc3, ctrl3);
//        flush from execute; writeback (we6, rd6, wb_data6); stage-4 register (valid4, op_a, op_b,
//        rs2_data4, rd4, we4, imm4, pc4, ctrl4).
module issue_stage #(
  parameter int XLEN  = 32,
  parameter int CTRLW = 24
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             valid3,
  output logic             ready3,
  input  logic [4:0]       rs1_3,
  input  logic [4:0]       rs2_3,
  input  logic [4:0]       rd3,
  input  logic             use_rs1_3,
  input  logic             use_rs2_3,
  input  logic             we3,
  input  logic             use_imm3,
  input  logic [XLEN-1:0]  imm3,
  input  logic [XLEN-1:0]  pc3,
  input  logic [CTRLW-1:0] ctrl3,
  input  logic             flush,
  input  logic             we6,
  input  logic [4:0]       rd6,
  input  logic [XLEN-1:0]  wb_data6,
  output logic             valid4,
  output logic [XLEN-1:0]  op_a,
  output logic [XLEN-1:0]  op_b,
  output logic [XLEN-1:0]  rs2_data4,
  output logic [4:0]       rd4,
  output logic             we4,
  output logic [XLEN-1:0]  imm4,
  output logic [XLEN-1:0]  pc4,
  output logic [CTRLW-1:0] ctrl4
);

  logic [XLEN-1:0] rf [32];
  logic [31:0]     pend;
  logic [31:0]     pend_eff;
  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic            stall;
  logic            fire;

  // A writeback landing this cycle already resolves its register, so the
  // consumer issues in the same cycle with the value taken from the bypass.
  always_comb begin
    pend_eff = pend;
    if (we6) pend_eff[rd6] = 1'b0;
    pend_eff[0] = 1'b0;
  end

  always_comb begin
    src1 = rf[rs1_3];
    if (we6 && rd6 == rs1_3) src1 = wb_data6;
    if (rs1_3 == 5'd0) src1 = '0;
    src2 = rf[rs2_3];
    if (we6 && rd6 == rs2_3) src2 = wb_data6;
    if (rs2_3 == 5'd0) src2 = '0;
  end

  // The rd3 term guards WAW: with one pending bit per register, a second
  // writer must not issue until the first has written back.
  assign stall = valid3 && ((use_rs1_3 && pend_eff[rs1_3]) ||
                            (use_rs2_3 && pend_eff[rs2_3]) ||
                            (we3 && rd3 != 5'd0 && pend_eff[rd3]));
  assign fire   = valid3 && !stall && !flush;
  assign ready3 = !stall || flush;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (we6 && rd6 != 5'd0) begin
      rf[rd6] <= wb_data6;
    end
  end

  // Set after clear so an issue and writeback on the same register leave it pending.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pend <= '0;
    end else begin
      if (we6) pend[rd6] <= 1'b0;
      if (fire && we3 && rd3 != 5'd0) pend[rd3] <= 1'b1;
    end
  end

  // Execute never stalls, so this register loads every cycle: instruction or bubble.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      valid4    <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      rs2_data4 <= '0;
      rd4       <= '0;
      we4       <= 1'b0;
      imm4      <= '0;
      pc4       <= '0;
      ctrl4     <= '0;
    end else if (fire) begin
      valid4    <= 1'b1;
      op_a      <= src1;
      op_b      <= use_imm3 ? imm3 : src2;
      rs2_data4 <= src2;
      rd4       <= rd3;
      we4       <= we3;
      imm4      <= imm3;
      pc4       <= pc3;
      ctrl4     <= ctrl3;
    end else begin
      valid4    <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      rs2_data4 <= '0;
      rd4       <= '0;
      we4       <= 1'b0;
      imm4      <= '0;
      pc4       <= '0;
      ctrl4     <= '0;
    end
  end

endmodule

// File: tb/tb_issue_stage.sv
module tb_issue_stage;
  logic        clk = 1'b0;
  logic        nrst;
  logic        valid3, ready3;
  logic [4:0]  rs1_3, rs2_3, rd3;
  logic        use_rs1_3, use_rs2_3, we3, use_imm3;
  logic [31:0] imm3, pc3;
  logic [23:0] ctrl3;
  logic        flush;
  logic        we6;
  logic [4:0]  rd6;
  logic [31:0] wb_data6;
  logic        valid4;
  logic [31:0] op_a, op_b, rs2_data4, imm4, pc4;
  logic [4:0]  rd4;
  logic        we4;
  logic [23:0] ctrl4;

  int checks = 0;
  int passed = 0;

  // Reference model: architectural register values plus a list of
  // destinations whose results are still in flight.
  logic [31:0] mrf [32];
  logic [4:0]  inflight [$];

  issue_stage #(.XLEN(32), .CTRLW(24)) dut (
    .clk(clk), .nrst(nrst), .valid3(valid3), .ready3(ready3),
    .rs1_3(rs1_3), .rs2_3(rs2_3), .rd3(rd3), .use_rs1_3(use_rs1_3), .use_rs2_3(use_rs2_3),
    .we3(we3), .use_imm3(use_imm3), .imm3(imm3), .pc3(pc3), .ctrl3(ctrl3), .flush(flush),
    .we6(we6), .rd6(rd6), .wb_data6(wb_data6), .valid4(valid4), .op_a(op_a), .op_b(op_b),
    .rs2_data4(rs2_data4), .rd4(rd4), .we4(we4), .imm4(imm4), .pc4(pc4), .ctrl4(ctrl4)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic instr(input bit v, input bit [4:0] a, input bit [4:0] b, input bit [4:0] d,
                       input bit u1, input bit u2, input bit w, input bit ui,
                       input bit [31:0] imm, input bit [31:0] pc, input bit [23:0] ctrl);
    valid3 = v; rs1_3 = a; rs2_3 = b; rd3 = d; use_rs1_3 = u1; use_rs2_3 = u2;
    we3 = w; use_imm3 = ui; imm3 = imm; pc3 = pc; ctrl3 = ctrl;
  endtask

  task automatic wb(input bit w, input bit [4:0] r, input bit [31:0] data);
    we6 = w; rd6 = r; wb_data6 = data;
  endtask

  function automatic bit busy(input logic [4:0] r);
    bit hit = 0;
    foreach (inflight[i]) if (inflight[i] == r) hit = 1;
    return hit && r != 5'd0 && !(we6 && rd6 == r);
  endfunction

  function automatic logic [31:0] msrc(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (we6 && rd6 == r) return wb_data6;
    return mrf[r];
  endfunction

  function automatic logic [63:0] z(input logic [31:0] v);
    return {32'd0, v};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mrf[i] = 32'd0;
    inflight.delete();
  endtask

  // One cycle: inputs are already driven (clk low); check ready3, clock,
  // check the stage-4 register, then advance the model.
  task automatic step();
    bit st, fr;
    logic [31:0] s1, s2;
    #1;
    st = valid3 && ((use_rs1_3 && busy(rs1_3)) || (use_rs2_3 && busy(rs2_3)) ||
                    (we3 && rd3 != 5'd0 && busy(rd3)));
    fr = valid3 && !st && !flush;
    s1 = msrc(rs1_3);
    s2 = msrc(rs2_3);
    chk("ready3", {63'd0, ready3}, {63'd0, !st || flush});
    @(posedge clk);
    #1;
    chk("valid4", {63'd0, valid4}, {63'd0, fr});
    chk("op_a", z(op_a), fr ? z(s1) : 64'd0);
    chk("op_b", z(op_b), fr ? z(use_imm3 ? imm3 : s2) : 64'd0);
    chk("rs2_data4", z(rs2_data4), fr ? z(s2) : 64'd0);
    chk("rd4", {59'd0, rd4}, fr ? {59'd0, rd3} : 64'd0);
    chk("we4", {63'd0, we4}, {63'd0, fr && we3});
    chk("imm4", z(imm4), fr ? z(imm3) : 64'd0);
    chk("pc4", z(pc4), fr ? z(pc3) : 64'd0);
    chk("ctrl4", {40'd0, ctrl4}, fr ? {40'd0, ctrl3} : 64'd0);
    if (we6) begin
      for (int i = inflight.size() - 1; i >= 0; i--)
        if (inflight[i] == rd6) inflight.delete(i);
      if (rd6 != 5'd0) mrf[rd6] = wb_data6;
    end
    if (fr && we3 && rd3 != 5'd0) inflight.push_back(rd3);
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    wb(0, 0, 0);
    flush = 0;
    nrst = 0;

    // Reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready3", {63'd0, ready3}, 64'd1);
    chk("rst_valid4", {63'd0, valid4}, 64'd0);
    @(negedge clk);
    nrst = 1;
    #1;
    chk("post_rst_op_a", z(op_a), 64'd0);
    chk("post_rst_ctrl4", {40'd0, ctrl4}, 64'd0);
    chk("post_rst_ready3", {63'd0, ready3}, 64'd1);
    instr(1, 3, 17, 0, 1, 1, 0, 0, 32'h0, 32'h100, 24'h1);
    step();
    chk("rst_read_zero", z(op_a | op_b), 64'd0);

    // Back-to-back RAW: addi x5 then add x6,x5,x5
    instr(1, 0, 0, 5, 1, 0, 1, 1, 32'h7, 32'h104, 24'h2);
    step();
    instr(1, 5, 5, 6, 1, 1, 1, 0, 32'h0, 32'h108, 24'h3);
    step();
    chk("raw_stall_ready3", {63'd0, ready3}, 64'd0);
    step();
    wb(1, 5, 32'h0000_0007);
    step();
    chk("raw_issue_op_a", z(op_a), 64'd7);
    chk("raw_issue_op_b", z(op_b), 64'd7);
    wb(1, 6, 32'h0000_000e);
    instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();

    // x0 handling
    wb(1, 0, 32'hDEAD_BEEF);
    instr(1, 0, 0, 0, 1, 0, 1, 0, 32'h0, 32'h10c, 24'h4);
    step();
    chk("x0_op_a", z(op_a), 64'd0);
    wb(0, 0, 0);
    instr(1, 0, 0, 0, 1, 1, 1, 0, 32'h0, 32'h110, 24'h5);
    step();
    chk("x0_no_stall", {63'd0, valid4}, 64'd1);

    // WAW on x8
    instr(1, 1, 0, 8, 1, 0, 1, 1, 32'h0, 32'h114, 24'h6);
    step();
    instr(1, 0, 0, 8, 0, 0, 1, 1, 32'h5, 32'h118, 24'h7);
    step();
    chk("waw_stall", {63'd0, ready3}, 64'd0);
    wb(1, 8, 32'h0000_0088);
    step();
    chk("waw_issue", {63'd0, valid4}, 64'd1);
    wb(0, 0, 0);
    instr(1, 8, 0, 2, 1, 0, 1, 0, 32'h0, 32'h11c, 24'h8);
    step();
    chk("waw_pend_set_again", {63'd0, ready3}, 64'd0);
    wb(1, 8, 32'h0000_0099);
    step();

    // Flush kills a stalled instruction; its rd10 is not marked pending
    wb(0, 0, 0);
    instr(1, 0, 0, 9, 0, 0, 1, 1, 32'h9, 32'h120, 24'h9);
    step();
    instr(1, 9, 0, 10, 1, 0, 1, 0, 32'h0, 32'h124, 24'ha);
    flush = 1;
    step();
    chk("flush_ready3", {63'd0, ready3}, 64'd1);
    chk("flush_bubble", {63'd0, valid4}, 64'd0);
    flush = 0;
    instr(1, 10, 0, 11, 1, 0, 0, 0, 32'h0, 32'h128, 24'hb);
    step();
    chk("flush_no_pend", {63'd0, valid4}, 64'd1);
    wb(1, 9, 32'h0000_0999);
    instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();

    // Immediate select
    wb(1, 12, 32'h0000_0011);
    step();
    wb(0, 0, 0);
    instr(1, 0, 12, 13, 0, 1, 1, 1, 32'hFFFF_FFF0, 32'h12c, 24'hc);
    step();
    chk("imm_op_b", z(op_b), 64'hFFFF_FFF0);
    chk("imm_rs2_data4", z(rs2_data4), 64'h11);
    wb(1, 13, 32'h1234_5678);
    instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();

    // Randomized traffic with a reset in the middle
    for (int c = 0; c < 400; c++) begin
      if (c == 200) begin
        nrst = 0;
        #1;
        chk("midrst_ready3", {63'd0, ready3}, 64'd1);
        chk("midrst_valid4", {63'd0, valid4}, 64'd0);
        model_reset();
        @(negedge clk);
        nrst = 1;
      end
      instr(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom(), $urandom(),
            24'($urandom()));
      flush = ($urandom_range(0, 7) == 0);
      if (inflight.size() != 0 && $urandom_range(0, 2) == 0)
        wb(1, inflight[$urandom_range(0, inflight.size() - 1)], $urandom());
      else if ($urandom_range(0, 5) == 0)
        wb(1, 5'($urandom_range(0, 7)), $urandom());
      else
        wb(0, 5'($urandom_range(0, 7)), $urandom());
      step();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
